// File: rtl/ram_arbiter_n_if.sv
// Bundle of per-CPU cache request/response signals and the shared RAM port
// seen by the N-CPU RAM arbiter.
interface ram_arbiter_n_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*DATA_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*DATA_W-1:0] iload;
  logic [CPUS*DATA_W-1:0] dload;
  logic [ADDR_W-1:0]      ramaddr;
  logic [DATA_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  logic [DATA_W-1:0]      ramload;
  logic [1:0]             ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );
endinterface

// File: rtl/ram_arbiter_n.sv
// Round-robin arbiter serialising 2*CPUS request slots (data at 2k, fetch at
// 2k+1) onto a single RAM port; each grant lasts until ACCESS, ERROR or withdrawal.
module ram_arbiter_n #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  ram_arbiter_n_if.master  bus
);
  localparam int SLOTS = 2 * CPUS;
  localparam int IDX_W = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [SLOTS-1:0]  active;
  logic [SLOTS-1:0]  slot_wr;
  logic [SLOTS-1:0]  done;
  logic [ADDR_W-1:0] slot_addr  [SLOTS];
  logic [DATA_W-1:0] slot_store [SLOTS];

  logic              found;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  rr_next;
  logic              live;
  logic [ADDR_W-1:0] ramaddr_c;
  logic [DATA_W-1:0] ramstore_c;
  logic              ramren_c;
  logic              ramwen_c;

  // Flatten the per-CPU buses into a slot-indexed view.
  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_cpu
      assign active[2*gi]     = bus.dREN[gi] | bus.dWEN[gi];
      assign active[2*gi+1]   = bus.iREN[gi];
      assign slot_wr[2*gi]    = bus.dWEN[gi];
      assign slot_wr[2*gi+1]  = 1'b0;
      assign slot_addr[2*gi]   = bus.daddr[gi*ADDR_W +: ADDR_W];
      assign slot_addr[2*gi+1] = bus.iaddr[gi*ADDR_W +: ADDR_W];
      assign slot_store[2*gi]   = bus.dstore[gi*DATA_W +: DATA_W];
      assign slot_store[2*gi+1] = '0;
      assign bus.dwait[gi] = ~done[2*gi];
      assign bus.iwait[gi] = ~done[2*gi+1];
      assign bus.iload[gi*DATA_W +: DATA_W] = bus.ramload;
      assign bus.dload[gi*DATA_W +: DATA_W] = bus.ramload;
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (!found && active[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  assign rr_next = (grant_q == IDX_W'(SLOTS - 1)) ? '0 : grant_q + IDX_W'(1);
  assign live    = active[grant_q];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    done       = '0;
    ramaddr_c  = '0;
    ramstore_c = '0;
    ramren_c   = 1'b0;
    ramwen_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ramaddr_c  = slot_addr[grant_q];
        ramstore_c = slot_store[grant_q];
        // Strobes follow the live enable so a withdrawn request drops them at once.
        ramwen_c   = live & slot_wr[grant_q];
        ramren_c   = live & ~slot_wr[grant_q];
        if (!live) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ACCESS) begin
          done[grant_q] = 1'b1;
          state_d       = IDLE;
          rr_d          = rr_next;
        end else if (bus.ramstate == RS_ERROR) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ramaddr  = ramaddr_c;
  assign bus.ramstore = ramstore_c;
  assign bus.ramREN   = ramren_c;
  assign bus.ramWEN   = ramwen_c;
endmodule
